muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit, parametrised in width; companion to the single-cycle ALU.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/dl_adder.sv | 19 +
 rtl/muldiv_cond_neg.sv | 17 +
 rtl/muldiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative RV32M multiply/divide unit.
//   muldiv_op_t    : operation encoding, equal to the RV32M funct3 field.
//   muldiv_state_t : control FSM states.
//   Helpers report which operands an operation treats as signed.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OpMul    = 3'd0,
      OpMulh   = 3'd1,
      OpMulhsu = 3'd2,
      OpMulhu  = 3'd3,
      OpDiv    = 3'd4,
      OpDivu   = 3'd5,
      OpRem    = 3'd6,
      OpRemu   = 3'd7
   } muldiv_op_t;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StCalc,
      StFix,
      StDone
   } muldiv_state_t;

   // MUL needs no sign handling: the low product word is sign-agnostic.
   function automatic logic rs1_is_signed(input muldiv_op_t op);
      return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
   endfunction

   function automatic logic rs2_is_signed(input muldiv_op_t op);
      return op inside {OpMulh, OpDiv, OpRem};
   endfunction

endpackage

// File: rtl/dl_adder.sv
// dl_adder: plain WIDTH-bit adder with carry-in, shared by the multiply accumulate
// and the restoring-divide trial subtraction.
//   a_i, b_i : addends
//   cin_i    : carry-in (1 with an inverted b_i gives a - b)
//   sum_o    : a_i + b_i + cin_i, truncated to WIDTH bits
module dl_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o
);

   always_comb begin
      sum_o = a_i + b_i + WIDTH'(cin_i);
   end

endmodule

// File: rtl/muldiv_cond_neg.sv
// muldiv_cond_neg: conditional two's-complement negation.
//   in_i  : value
//   neg_i : 1 -> out_o = -in_i, 0 -> out_o = in_i
//   out_o : result
module muldiv_cond_neg #(
   parameter int unsigned NUM_BITS = 32
) (
   input  logic [NUM_BITS-1:0] in_i,
   input  logic                neg_i,
   output logic [NUM_BITS-1:0] out_o
);

   always_comb begin
      out_o = neg_i ? (~in_i + NUM_BITS'(1)) : in_i;
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (one bit per cycle).
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake; ready only while idle
//   req_op                : RV32M funct3 (MUL..REMU)
//   req_in0, req_in1      : rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   flush                 : abandon the operation in flight, no response
//   resp_valid/resp_ready : response handshake; resp_data held while waiting
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the
// remaining multiplier bits are all zero.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned N_BITS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [N_BITS-1:0] req_in0,
   input  logic [N_BITS-1:0] req_in1,
   input  logic              flush,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [N_BITS-1:0] resp_data
);

   localparam int unsigned CNT_W = $clog2(N_BITS);
   localparam int unsigned W2    = 2 * N_BITS;

   muldiv_state_t     state_q, state_d;
   muldiv_op_t        op_q, op_d;
   logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
   // acc: product accumulator (mul) / partial remainder in the low word (div)
   // mc : multiplicand shifted left (mul) / divisor magnitude in the low word (div)
   // sh : multiplier shifted right (mul) / dividend bits out, quotient bits in (div)
   logic [W2-1:0]     acc_q, acc_d, mc_q, mc_d;
   logic [N_BITS-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_BITS-1:0] resp_data_q, resp_data_d;

   logic              is_div, sign_a, sign_b, div_zero, div_ovf;
   logic [N_BITS-1:0] a_mag, b_mag, special_res;
   logic [N_BITS:0]   rem_shift;
   logic [W2-1:0]     add_a, add_b, add_sum;
   logic              borrow;
   logic [W2-1:0]     fix_in, fix_out;
   logic              fix_neg;
   logic [N_BITS-1:0] result;

   assign is_div = op_q[2];
   assign sign_a = a_q[N_BITS-1] & rs1_is_signed(op_q);
   assign sign_b = b_q[N_BITS-1] & rs2_is_signed(op_q);

   muldiv_cond_neg #(.NUM_BITS(N_BITS)) u_mag_a (
      .in_i  (a_q),
      .neg_i (sign_a),
      .out_o (a_mag)
   );

   muldiv_cond_neg #(.NUM_BITS(N_BITS)) u_mag_b (
      .in_i  (b_q),
      .neg_i (sign_b),
      .out_o (b_mag)
   );

   // Special cases bypass the iteration entirely.
   always_comb begin
      div_zero    = (b_q == '0);
      div_ovf     = (op_q inside {OpDiv, OpRem}) && (a_q == {1'b1, {(N_BITS - 1){1'b0}}})
                    && (b_q == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = op_q[1] ? a_q : '1;
      end else if (div_ovf) begin
         special_res = op_q[1] ? '0 : a_q;
      end
   end

   // Divide: trial-subtract divisor from (remainder << 1 | next dividend bit).
   assign rem_shift = {acc_q[N_BITS-1:0], sh_q[N_BITS-1]};

   always_comb begin
      if (is_div) begin
         add_a = W2'(rem_shift);
         add_b = ~(W2'(mc_q[N_BITS-1:0]));
      end else begin
         add_a = acc_q;
         add_b = mc_q;
      end
   end

   dl_adder #(.WIDTH(W2)) u_adder (
      .a_i   (add_a),
      .b_i   (add_b),
      .cin_i (is_div),
      .sum_o (add_sum)
   );

   // Both trial operands are below 2^(N+1), so the top bit of the 2N-bit difference is the borrow.
   assign borrow = add_sum[W2-1];

   // Sign fix: product and quotient negate on differing signs, remainder follows the dividend.
   always_comb begin
      if (is_div && op_q[1]) begin
         fix_in  = W2'(acc_q[N_BITS-1:0]);
         fix_neg = sign_a;
      end else if (is_div) begin
         fix_in  = W2'(sh_q);
         fix_neg = sign_a ^ sign_b;
      end else begin
         fix_in  = acc_q;
         fix_neg = sign_a ^ sign_b;
      end
   end

   muldiv_cond_neg #(.NUM_BITS(W2)) u_fix (
      .in_i  (fix_in),
      .neg_i (fix_neg),
      .out_o (fix_out)
   );

   assign result = (is_div || op_q == OpMul) ? fix_out[N_BITS-1:0] : fix_out[W2-1:N_BITS];

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      mc_d        = mc_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      resp_data_d = resp_data_q;

      if (flush) begin
         // In idle a flush only blocks acceptance; elsewhere it kills the op.
         if (state_q != StIdle) begin
            state_d = StIdle;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  op_d    = muldiv_op_t'(req_op);
                  a_d     = req_in0;
                  b_d     = req_in1;
                  state_d = StPrep;
               end
            end
            StPrep: begin
               if (is_div && (div_zero || div_ovf)) begin
                  resp_data_d = special_res;
                  state_d     = StDone;
               end else begin
                  acc_d   = '0;
                  cnt_d   = CNT_W'(N_BITS - 1);
                  state_d = StCalc;
                  if (is_div) begin
                     mc_d = W2'(b_mag);
                     sh_d = a_mag;
                  end else begin
                     mc_d = W2'(a_mag);
                     sh_d = b_mag;
                  end
               end
            end
            StCalc: begin
               if (is_div) begin
                  acc_d = borrow ? W2'(rem_shift[N_BITS-1:0]) : W2'(add_sum[N_BITS-1:0]);
                  sh_d  = {sh_q[N_BITS-2:0], ~borrow};
               end else begin
                  if (sh_q[0]) begin
                     acc_d = add_sum;
                  end
                  mc_d = mc_q << 1;
                  sh_d = sh_q >> 1;
               end
               if (cnt_q == '0) begin
                  state_d = StFix;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
`ifdef MULDIV_EARLY_OUT_EN
               // Remaining multiplier bits all zero: further iterations add nothing.
               if (!is_div && ((sh_q >> 1) == '0)) begin
                  state_d = StFix;
               end
`endif
            end
            StFix: begin
               resp_data_d = result;
               state_d     = StDone;
            end
            StDone: begin
               if (resp_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= OpMul;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         mc_q        <= '0;
         sh_q        <= '0;
         cnt_q       <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         mc_q        <= mc_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StDone);
   assign resp_data  = resp_data_q;

endmodule
